// File: rtl/fuzzy_defuzz_seq_pkg.sv
// Shared types and width helpers for the sequential interval type-2 defuzzifier.
package fuzzy_pkg;

    typedef enum logic [1:0] {
        ACC  = 2'd0,
        RND  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int W_DEF        = 8;
    localparam int N_RULES_DEF  = 9;
    localparam int ZERO_OUT_DEF = 128;

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int num_w(input int w, input int n);
        return 2 * w + cnt_w(n);
    endfunction

    function automatic int den_w(input int w, input int n);
        return w + cnt_w(n);
    endfunction

endpackage

// File: rtl/fuzzy_defuzz_seq_if.sv
// Rule-beat input stream and crisp-result output stream of the defuzzifier.
interface fuzzy_defuzz_seq_if #(
    parameter int W       = 8,
    parameter int N_RULES = 9
);
    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       fire_up;
    logic [W-1:0]       fire_low;
    logic [W-1:0]       centroid;
    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       out_data;
    logic [N_RULES-1:0] active_mask;
    logic               busy;

    modport master (
        output in_valid, fire_up, fire_low, centroid, out_ready,
        input  in_ready, out_valid, out_data, active_mask, busy
    );

    modport slave (
        input  in_valid, fire_up, fire_low, centroid, out_ready,
        output in_ready, out_valid, out_data, active_mask, busy
    );
endinterface

// File: rtl/fuzzy_defuzz_seq_divider.sv
// Restoring divider, one quotient bit per cycle MSB first; caller guarantees num < den << W.
module fuzzy_seq_divider #(
    parameter int W  = 8,
    parameter int NW = 18,
    parameter int DW = 10
) (
    input  logic          clk_0,
    input  logic          Srst_n,
    input  logic          abort,
    input  logic          start,
    input  logic [NW-1:0] num,
    input  logic [DW-1:0] den,
    output logic          done,
    output logic [W-1:0]  quotient
);
    localparam int CTW = $clog2(W + 1);

    logic [DW-1:0]  rem, den_r, rem_nxt;
    logic [W-1:0]   lo;
    logic [W-2:0]   q;
    logic [CTW-1:0] cnt;
    logic [DW:0]    trial, diff;
    logic           ge;

    // borrow out of the trial subtraction decides the quotient bit
    assign trial    = {rem, lo[W-1]};
    assign diff     = trial - {1'b0, den_r};
    assign ge       = ~diff[DW];
    assign rem_nxt  = ge ? diff[DW-1:0] : trial[DW-1:0];
    assign quotient = {q, ge};
    assign done     = (cnt == CTW'(1));

    always_ff @(posedge clk_0 or negedge Srst_n) begin
        if (!Srst_n) begin
            rem   <= '0;
            den_r <= '0;
            lo    <= '0;
            q     <= '0;
            cnt   <= '0;
        end else if (abort) begin
            cnt <= '0;
        end else if (start) begin
            rem   <= num[NW-1:W];
            lo    <= num[W-1:0];
            den_r <= den;
            q     <= '0;
            cnt   <= CTW'(W);
        end else if (cnt != '0) begin
            rem <= rem_nxt;
            lo  <= {lo[W-2:0], 1'b0};
            q   <= quotient[W-2:0];
            cnt <= cnt - CTW'(1);
        end
    end
endmodule

// File: rtl/fuzzy_defuzz_seq.sv
// Sequential Nie-Tan type reduction plus weighted-average centroid defuzzifier.
// Define FUZZY_DEFUZZ_ROUND_EN for round-to-nearest division (adds one RND cycle).
module fuzzy_defuzz_seq
    import fuzzy_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int N_RULES  = N_RULES_DEF,
    parameter int ZERO_OUT = ZERO_OUT_DEF
) (
    input  logic clk_0,
    input  logic Srst_n,
    input  logic clr,
    fuzzy_defuzz_seq_if.slave bus
);
    localparam int CW = cnt_w(N_RULES);
    localparam int NW = num_w(W, N_RULES);
    localparam int DW = den_w(W, N_RULES);

    state_t             state, state_nxt;
    logic [CW-1:0]      idx;
    logic [NW-1:0]      num, num_nxt, div_num;
    logic [DW-1:0]      den, den_nxt, div_den;
    logic [N_RULES-1:0] mask_acc, mask_nxt, mask_out;
    logic [W-1:0]       w, out_q, div_q, res_q;
    logic [2*W-1:0]     prod;
    logic               beat, last, den_zero, div_start, div_done;

    assign beat     = bus.in_valid && bus.in_ready;
    assign last     = (idx == CW'(N_RULES - 1));
    assign w        = W'(({1'b0, bus.fire_up} + {1'b0, bus.fire_low}) >> 1);
    assign prod     = w * bus.centroid;
    assign num_nxt  = num + NW'(prod);
    assign den_nxt  = den + DW'(w);
    assign den_zero = (den_nxt == '0);

    always_comb begin
        mask_nxt = mask_acc;
        for (int k = 0; k < N_RULES; k++)
            if (idx == CW'(k) && bus.fire_up != '0) mask_nxt[k] = 1'b1;
    end

`ifdef FUZZY_DEFUZZ_ROUND_EN
    logic sat;

    // bias by half the divisor for round-to-nearest; clamp if the quotient would not fit
    assign div_start = (state == RND) && !clr;
    assign div_num   = num + NW'(den >> 1);
    assign div_den   = den;
    assign res_q     = sat ? '1 : div_q;

    always_ff @(posedge clk_0 or negedge Srst_n) begin
        if (!Srst_n)        sat <= 1'b0;
        else if (div_start) sat <= (div_num[NW-1:W] >= den);
    end
`else
    assign div_start = beat && last && !den_zero && !clr;
    assign div_num   = num_nxt;
    assign div_den   = den_nxt;
    assign res_q     = div_q;
`endif

    fuzzy_seq_divider #(.W(W), .NW(NW), .DW(DW)) u_div (
        .clk_0    (clk_0),
        .Srst_n   (Srst_n),
        .abort    (clr),
        .start    (div_start),
        .num      (div_num),
        .den      (div_den),
        .done     (div_done),
        .quotient (div_q)
    );

    always_ff @(posedge clk_0 or negedge Srst_n) begin
        if (!Srst_n) state <= ACC;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = ACC;
        end else begin
            case (state)
                ACC: if (beat && last) begin
                    if (den_zero) state_nxt = DONE;
`ifdef FUZZY_DEFUZZ_ROUND_EN
                    else          state_nxt = RND;
`else
                    else          state_nxt = DIV;
`endif
                end
                RND:     state_nxt = DIV;
                DIV:     if (div_done) state_nxt = DONE;
                DONE:    if (bus.out_ready) state_nxt = ACC;
                default: state_nxt = ACC;
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = (state == ACC);
        bus.out_valid = (state == DONE);
        bus.busy      = (state != ACC) || (idx != '0);
    end

    assign bus.out_data    = out_q;
    assign bus.active_mask = mask_out;

    // out_q / mask_out survive clr so the last presented result stays visible
    always_ff @(posedge clk_0 or negedge Srst_n) begin
        if (!Srst_n) begin
            idx      <= '0;
            num      <= '0;
            den      <= '0;
            mask_acc <= '0;
            out_q    <= '0;
            mask_out <= '0;
        end else if (clr) begin
            idx      <= '0;
            num      <= '0;
            den      <= '0;
            mask_acc <= '0;
        end else begin
            if (beat) begin
                idx      <= last ? '0 : idx + CW'(1);
                num      <= num_nxt;
                den      <= den_nxt;
                mask_acc <= mask_nxt;
                if (last && den_zero) begin
                    out_q    <= W'(ZERO_OUT);
                    mask_out <= mask_nxt;
                end
            end
            if (state == DIV && div_done) begin
                out_q    <= res_q;
                mask_out <= mask_acc;
            end
            if (state == DONE && bus.out_ready) begin
                num      <= '0;
                den      <= '0;
                mask_acc <= '0;
            end
        end
    end
endmodule

// File: tb/tb_fuzzy_defuzz_seq.sv
// Randomized and directed bench for fuzzy_defuzz_seq (W=8, N_RULES=3) against a frame-level model.
module tb_fuzzy_defuzz_seq;
    localparam int W  = 8;
    localparam int N  = 3;
    localparam int ZO = 128;

    logic clk_0  = 1'b0;
    logic Srst_n = 1'b0;
    logic clr    = 1'b0;

    fuzzy_defuzz_seq_if #(.W(W), .N_RULES(N)) bus ();

    fuzzy_defuzz_seq #(.W(W), .N_RULES(N), .ZERO_OUT(ZO)) dut (
        .clk_0  (clk_0),
        .Srst_n (Srst_n),
        .clr    (clr),
        .bus    (bus)
    );

    always #5 clk_0 = ~clk_0;

    int total = 0;
    int bad   = 0;
    int fu[N], fl[N], fc[N];
    int exp_q, exp_mask, exp_lat;
    int hold_q, hold_m;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_0);
        #1;
    endtask

    // frame-level reference: Nie-Tan weights, centroid average, zero-weight fallback
    function automatic void model();
        int num, den, wt;
        num = 0;
        den = 0;
        exp_mask = 0;
        for (int k = 0; k < N; k++) begin
            wt  = (fu[k] + fl[k]) / 2;
            num += wt * fc[k];
            den += wt;
            if (fu[k] != 0) exp_mask |= (1 << k);
        end
        if (den == 0) begin
            exp_q   = ZO;
            exp_lat = 1;
        end else begin
`ifdef FUZZY_DEFUZZ_ROUND_EN
            exp_q   = (num + den / 2) / den;
            if (exp_q > 255) exp_q = 255;
            exp_lat = W + 2;
`else
            exp_q   = num / den;
            exp_lat = W + 1;
`endif
        end
    endfunction

    task automatic set_beat(input int k, input int u, input int l, input int c);
        fu[k] = u;
        fl[k] = l;
        fc[k] = c;
    endtask

    task automatic rand_frame(input bit allow_zero);
        for (int k = 0; k < N; k++) begin
            fu[k] = $urandom_range(0, 255);
            fl[k] = $urandom_range(0, 255);
            fc[k] = $urandom_range(0, 255);
            if (allow_zero && $urandom_range(0, 3) == 0) begin
                fu[k] = 0;
                if ($urandom_range(0, 1) == 0) fl[k] = 0;
            end
        end
    endtask

    task automatic send_beat(input int k);
        bus.in_valid = 1'b1;
        bus.fire_up  = W'(fu[k]);
        bus.fire_low = W'(fl[k]);
        bus.centroid = W'(fc[k]);
        for (int t = 0; t < 100 && !bus.in_ready; t++) tick();
        chk("beat_ready", int'(bus.in_ready), 1);
        tick();
    endtask

    task automatic send_frame();
        for (int k = 0; k < N; k++) send_beat(k);
    endtask

    task automatic wait_result(input string tag);
        int lat;
        lat = 1;
        bus.in_valid = 1'b0;
        model();
        while (!bus.out_valid && lat < 60) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_data"}, int'(bus.out_data), exp_q);
        chk({tag, "_mask"}, int'(bus.active_mask), exp_mask);
        chk({tag, "_inrdy"}, int'(bus.in_ready), 0);
    endtask

    task automatic ack(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_ack_ov"}, int'(bus.out_valid), 0);
        chk({tag, "_ack_ir"}, int'(bus.in_ready), 1);
    endtask

    task automatic set_mixed();
        set_beat(0, 200, 100, 64);
        set_beat(1, 0, 0, 128);
        set_beat(2, 100, 100, 192);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.fire_up   = '0;
        bus.fire_low  = '0;
        bus.centroid  = '0;
        bus.out_ready = 1'b0;

        #3;
        chk("rst_ov", int'(bus.out_valid), 0);
        chk("rst_ir", int'(bus.in_ready), 1);
        chk("rst_data", int'(bus.out_data), 0);
        chk("rst_mask", int'(bus.active_mask), 0);
        chk("rst_busy", int'(bus.busy), 0);
        #9 Srst_n = 1'b1;
        tick();

        set_mixed();
        send_frame();
        wait_result("mixed");
        chk("mixed_const", int'(bus.out_data), 115);
        ack("mixed");

        for (int k = 0; k < N; k++) set_beat(k, 0, 0, $urandom_range(0, 255));
        send_frame();
        wait_result("zero");
        ack("zero");

        for (int k = 0; k < N; k++) set_beat(k, 255, 255, 255);
        send_frame();
        wait_result("max");
        ack("max");

        set_beat(0, 2, 0, 1);
        set_beat(1, 2, 0, 2);
        set_beat(2, 2, 0, 2);
        send_frame();
        wait_result("round");
        ack("round");

        // backpressure: result held while the next frame's first beat waits
        rand_frame(1'b0);
        send_frame();
        wait_result("bpA");
        hold_q = exp_q;
        hold_m = exp_mask;
        rand_frame(1'b0);
        bus.in_valid = 1'b1;
        bus.fire_up  = W'(fu[0]);
        bus.fire_low = W'(fl[0]);
        bus.centroid = W'(fc[0]);
        for (int t = 0; t < 20; t++) begin
            tick();
            chk("bp_data", int'(bus.out_data), hold_q);
            chk("bp_mask", int'(bus.active_mask), hold_m);
            chk("bp_ir", int'(bus.in_ready), 0);
            chk("bp_ov", int'(bus.out_valid), 1);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_rel_ir", int'(bus.in_ready), 1);
        chk("bp_rel_busy", int'(bus.busy), 0);
        chk("bp_rel_ov", int'(bus.out_valid), 0);
        tick();
        chk("bp_beat0_taken", int'(bus.busy), 1);
        send_beat(1);
        send_beat(2);
        wait_result("bpB");
        ack("bpB");
        hold_q = exp_q;

        // abort after two beats, then a clean frame
        rand_frame(1'b0);
        send_beat(0);
        send_beat(1);
        bus.in_valid = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_busy", int'(bus.busy), 0);
        chk("clr_ov", int'(bus.out_valid), 0);
        chk("clr_keep", int'(bus.out_data), hold_q);
        set_mixed();
        send_frame();
        wait_result("clrmix");
        ack("clrmix");

        // clr together with the output handshake drops the result
        rand_frame(1'b0);
        send_frame();
        wait_result("clrhs");
        bus.out_ready = 1'b1;
        clr = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        clr = 1'b0;
        chk("clrhs_ov", int'(bus.out_valid), 0);
        chk("clrhs_ir", int'(bus.in_ready), 1);
        chk("clrhs_keep", int'(bus.out_data), exp_q);

        // asynchronous reset while dividing
        set_mixed();
        send_frame();
        bus.in_valid = 1'b0;
        tick();
        tick();
        Srst_n = 1'b0;
        #1;
        chk("rstdiv_ov", int'(bus.out_valid), 0);
        chk("rstdiv_ir", int'(bus.in_ready), 1);
        chk("rstdiv_data", int'(bus.out_data), 0);
        chk("rstdiv_mask", int'(bus.active_mask), 0);
        chk("rstdiv_busy", int'(bus.busy), 0);
        #2 Srst_n = 1'b1;
        tick();
        chk("rstdiv_rel_ir", int'(bus.in_ready), 1);

        for (int f = 0; f < 30; f++) begin
            rand_frame(1'b1);
            send_frame();
            wait_result("rand");
            for (int d = $urandom_range(0, 3); d > 0; d--) tick();
            ack("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fuzzy_defuzz_seq.md
Name: fuzzy_defuzz_seq

Overview:
- Parametrised sequential defuzzifier (type-reduction plus weighted-average centroid) for the interval type-2 fuzzy processor.
- Generalises the fixed 8-bit, fixed-rule-count combinational defuzzifier to W-bit data and N_RULES rules.
- Rule firing strengths arrive serially, with a valid/ready handshake, from the rule-evaluation stage.
- Produces one crisp output per frame through a multi-cycle divider, plus an active-rule mask (successor of FOU_ATIVO).

Parameters:
- W, 8, data width of firing strengths, centroids and crisp output.
- N_RULES, 9, rules per frame (>=2).
- ZERO_OUT, 128, crisp output when the total weight is zero (must fit in W bits).

Ports:
- clk_0  in  1  single system clock, rising edge.
- Srst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous abort; active high.
- in_valid  in  1  rule beat valid.
- in_ready  out  1  block can accept a beat.
- fire_up  in  W  upper firing strength of the current rule.
- fire_low  in  W  lower firing strength of the current rule.
- centroid  in  W  consequent centroid of the current rule.
- out_valid  out  1  crisp result available.
- out_ready  in  1  downstream accepts the result.
- out_data  out  W  crisp defuzzified output.
- active_mask  out  N_RULES  bit k set if rule k of the frame had fire_up != 0.
- busy  out  1  state is not ACC, or the frame beat count is nonzero.

Behaviour:
- Reset (Srst_n=0, asynchronous) sets:
  - state=ACC; in_ready=1; out_valid=0; out_data=0; active_mask=0; busy=0.
  - Accumulators and beat counter cleared.
- Beat transfer: a beat transfers on a rising edge where in_valid && in_ready. Beats are indexed 0..N_RULES-1 by an internal counter, width clog2(N_RULES).
- Per-beat weight: w = (fire_up + fire_low) >> 1, W bits (Nie-Tan reduction, truncating). The operands are not ordered; fire_low > fire_up is accepted as-is.
- Accumulators:
  - NUM += w*centroid, width 2W+clog2(N_RULES).
  - DEN += w, width W+clog2(N_RULES).
  - Neither can overflow.
- Active mask: the mask is built per frame. active_mask updates only when the result is presented, and holds until the next result.
- State ACC:
  - in_ready=1.
  - On the beat with index N_RULES-1: if DEN+w==0, go to DONE with out_data=ZERO_OUT. Otherwise go to DIV.
- State DIV:
  - in_ready=0.
  - Restoring divider, one quotient bit per cycle, MSB first, W cycles. Quotient = floor(NUM/DEN), always < 2^W.
  - Then go to DONE.
- State DONE:
  - out_valid=1, and out_data/active_mask are stable.
  - in_ready=0.
  - On out_valid && out_ready: clear accumulators and counter, go to ACC. in_ready=1 on the next cycle.
- Latency, counted from the edge accepting the final beat:
  - out_valid rises after W+1 edges in the nonzero case.
  - out_valid rises after 1 edge in the zero-weight case.
- clr=1 (priority over all handshakes): go to ACC next edge, clear accumulators, counter and out_valid. out_data and active_mask keep their last values.
- Simultaneous clr and output handshake: clr wins; the result is considered dropped.

Optional Feature:
- Macro: FUZZY_DEFUZZ_ROUND_EN.
- Defined: before DIV, one extra cycle (state RND) adds DEN>>1 to NUM. The result is round-to-nearest and latency becomes W+2. The result is saturated to 2^W-1.
- Undefined: truncating division, latency W+1, no RND state.

Decomposition:
- Package fuzzy_pkg:
  - state enum (ACC, RND, DIV, DONE).
  - clog2-based width constants (accumulator widths, counter width).
  - Default ZERO_OUT.
- Sub-module fuzzy_seq_divider:
  - Parametrised restoring divider.
  - Interface: start/done, numerator/denominator in, W-bit quotient out.
  - Instantiated once.

Test Plan (N_RULES=3, W=8):
- Mixed frame: beats (up,low,c) = (200,100,64), (0,0,128), (100,100,192) -> w = 150, 0, 100; NUM=28800, DEN=250.
  - Required: out_data=115, active_mask=3'b101, out_valid 9 edges after the last beat (ROUND_EN: 115, 10 edges).
- All beats zero -> out_data=128, active_mask=0, out_valid 1 edge after the last beat, divider never started.
- All beats (255,255,255) -> NUM=195075, DEN=765 -> out_data=255 with no overflow.
- Rounding: beats (2,0,1), (2,0,2), (2,0,2) -> NUM=5, DEN=3.
  - Required: out_data=1 without the macro; out_data=2 with FUZZY_DEFUZZ_ROUND_EN.
- Backpressure: out_ready=0 for 20 cycles.
  - Required: out_data/active_mask stable, in_ready=0, held in_valid beats not consumed.
  - On release: handshake, then the next frame's beat 0 is accepted the following edge.
- Reset and abort:
  - Srst_n=0 mid-DIV -> outputs immediately at reset values, in_ready=1 after release.
  - clr mid-frame after 2 beats -> the next 3 beats form a fresh frame, with the result as in the mixed-frame scenario.
